// File: rtl/button_events.sv
// Turns the debounced button level into one-cycle press, release, long-press
// and auto-repeat pulses, plus a held level, for the VGA mode/pattern select.
module button_events #(
    parameter int unsigned CNT_W         = 26,
    parameter int unsigned LONG_CYCLES   = 25000000,
    parameter int unsigned REPEAT_CYCLES = 5000000,
    parameter bit          REPEAT_EN     = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic button_i,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic repeat_o,
    output logic held_o
);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        LOCK   = 2'd0,
        IDLE   = 2'd1,
        PRESS  = 2'd2,
        REPEAT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_d, release_d, long_d, repeat_d, held_d;

    // State, hold counter and registered outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= LOCK;
            cnt_q     <= '0;
            press_o   <= 1'b0;
            release_o <= 1'b0;
            long_o    <= 1'b0;
            repeat_o  <= 1'b0;
            held_o    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_o   <= press_d;
            release_o <= release_d;
            long_o    <= long_d;
            repeat_o  <= repeat_d;
            held_o    <= held_d;
        end
    end

    // Next state and counter; release always wins over a terminal count
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            LOCK: begin
                cnt_d = '0;
                if (!button_i) state_d = IDLE;
            end
            IDLE: begin
                cnt_d = '0;
                if (button_i) state_d = PRESS;
            end
            PRESS: begin
                if (!button_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = REPEAT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
            end
            REPEAT: begin
                if (!button_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!REPEAT_EN || cnt_q == REPEAT_LAST) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
            end
            default: begin
                state_d = LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // Pulse decode; registered above so each pulse lands one cycle after its cause
    always_comb begin
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        held_d    = (state_d == PRESS) || (state_d == REPEAT);
        case (state_q)
            IDLE:    press_d = button_i;
            PRESS: begin
                release_d = !button_i;
                long_d    = button_i && (cnt_q == LONG_LAST);
            end
            REPEAT: begin
                release_d = !button_i;
                repeat_d  = REPEAT_EN && button_i && (cnt_q == REPEAT_LAST);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_button_events.sv
// Scoreboard bench for button_events: two instances (auto-repeat on/off) share
// one stimulus stream; expected pulse vectors come from the latency rules.
module tb_button_events;

    localparam int unsigned LONG = 8;
    localparam int unsigned REP  = 4;
    localparam int unsigned MAXN = 64;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic button = 1'b0;

    logic p1, r1, l1, rp1, h1;
    logic p0, r0, l0, rp0, h0;

    button_events #(.CNT_W(4), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .REPEAT_EN(1'b1)) dut_rep (
        .clock(clock), .reset(reset), .button_i(button),
        .press_o(p1), .release_o(r1), .long_o(l1), .repeat_o(rp1), .held_o(h1)
    );

    button_events #(.CNT_W(4), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .REPEAT_EN(1'b0)) dut_norep (
        .clock(clock), .reset(reset), .button_i(button),
        .press_o(p0), .release_o(r0), .long_o(l0), .repeat_o(rp0), .held_o(h0)
    );

    always #5 clock = ~clock;

    // Vector bit order: {press, release, long, repeat, held}
    localparam int PB = 4, RB = 3, LB = 2, PTB = 1, HB = 0;

    bit         b_s [MAXN];
    bit         r_s [MAXN];
    logic [4:0] e1_s[MAXN];
    logic [4:0] e0_s[MAXN];
    int         n_s;

    logic [4:0] q1[$], q0[$], o1[$], o0[$];
    int errors = 0;
    int checks = 0;

    task automatic start_build(input int n);
        n_s = n;
        for (int i = 0; i < MAXN; i++) begin
            b_s[i] = 1'b0; r_s[i] = 1'b1; e1_s[i] = '0; e0_s[i] = '0;
        end
    endtask

    // Button high for h samples from index t; expected pulses from latency rules
    function automatic void add_press(input int t, input int h);
        for (int j = 0; j < h && t + j < n_s; j++) begin
            b_s[t+j] = 1'b1;
            e1_s[t+j][HB] = 1'b1;
            e0_s[t+j][HB] = 1'b1;
        end
        e1_s[t][PB] = 1'b1;
        e0_s[t][PB] = 1'b1;
        if (int'(LONG) < h && t + int'(LONG) < n_s) begin
            e1_s[t+LONG][LB] = 1'b1;
            e0_s[t+LONG][LB] = 1'b1;
        end
        for (int k = t + int'(LONG) + int'(REP); k < t + h && k < n_s; k += int'(REP))
            e1_s[k][PTB] = 1'b1;
        if (t + h < n_s) begin
            e1_s[t+h][RB] = 1'b1;
            e0_s[t+h][RB] = 1'b1;
        end
    endfunction

    // Push expectations as stimulus is driven; capture outputs #1 after the edge
    task automatic run_build();
        for (int i = 0; i < n_s; i++) begin
            q1.push_back(e1_s[i]);
            q0.push_back(e0_s[i]);
            @(negedge clock);
            button = b_s[i];
            reset  = r_s[i];
            @(posedge clock);
            #1;
            o1.push_back({p1, r1, l1, rp1, h1});
            o0.push_back({p0, r0, l0, rp0, h0});
        end
    endtask

    task automatic test_reset();
        logic [4:0] exp, got;
        start_build(5);
        r_s[0] = 1'b0; r_s[1] = 1'b0;
        run_build();
        for (int i = 0; q1.size() > 0; i++) begin
            exp = q1.pop_front(); got = o1.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL reset rep cyc=%0d got=%b exp=%b", i, got, exp); end
            exp = q0.pop_front(); got = o0.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL reset norep cyc=%0d got=%b exp=%b", i, got, exp); end
        end
    endtask

    task automatic test_short_press();
        logic [4:0] exp, got;
        start_build(8);
        add_press(1, 3);
        run_build();
        for (int i = 0; q1.size() > 0; i++) begin
            exp = q1.pop_front(); got = o1.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL short_press rep cyc=%0d got=%b exp=%b", i, got, exp); end
            exp = q0.pop_front(); got = o0.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL short_press norep cyc=%0d got=%b exp=%b", i, got, exp); end
        end
    endtask

    task automatic test_min_press();
        logic [4:0] exp, got;
        start_build(5);
        add_press(1, 1);
        run_build();
        for (int i = 0; q1.size() > 0; i++) begin
            exp = q1.pop_front(); got = o1.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL min_press rep cyc=%0d got=%b exp=%b", i, got, exp); end
            exp = q0.pop_front(); got = o0.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL min_press norep cyc=%0d got=%b exp=%b", i, got, exp); end
        end
    endtask

    task automatic test_long_hold();
        logic [4:0] exp, got;
        start_build(24);
        add_press(1, 20);
        run_build();
        for (int i = 0; q1.size() > 0; i++) begin
            exp = q1.pop_front(); got = o1.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL long_hold rep cyc=%0d got=%b exp=%b", i, got, exp); end
            exp = q0.pop_front(); got = o0.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL long_hold norep cyc=%0d got=%b exp=%b", i, got, exp); end
        end
    endtask

    task automatic test_release_at_long();
        logic [4:0] exp, got;
        start_build(12);
        add_press(1, 8);
        run_build();
        for (int i = 0; q1.size() > 0; i++) begin
            exp = q1.pop_front(); got = o1.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL release_at_long rep cyc=%0d got=%b exp=%b", i, got, exp); end
            exp = q0.pop_front(); got = o0.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL release_at_long norep cyc=%0d got=%b exp=%b", i, got, exp); end
        end
    endtask

    task automatic test_lock_held();
        logic [4:0] exp, got;
        start_build(15);
        for (int i = 0; i < 6; i++) b_s[i] = 1'b1;
        r_s[0] = 1'b0; r_s[1] = 1'b0;
        add_press(9, 3);
        run_build();
        for (int i = 0; q1.size() > 0; i++) begin
            exp = q1.pop_front(); got = o1.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL lock_held rep cyc=%0d got=%b exp=%b", i, got, exp); end
            exp = q0.pop_front(); got = o0.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL lock_held norep cyc=%0d got=%b exp=%b", i, got, exp); end
        end
    endtask

    task automatic test_reset_mid_repeat();
        logic [4:0] exp, got;
        start_build(22);
        add_press(1, 14);
        for (int i = 11; i < n_s; i++) begin e1_s[i] = '0; e0_s[i] = '0; end
        r_s[11] = 1'b0;
        add_press(17, 2);
        run_build();
        for (int i = 0; q1.size() > 0; i++) begin
            exp = q1.pop_front(); got = o1.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL reset_mid_repeat rep cyc=%0d got=%b exp=%b", i, got, exp); end
            exp = q0.pop_front(); got = o0.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL reset_mid_repeat norep cyc=%0d got=%b exp=%b", i, got, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_short_press();
        test_min_press();
        test_long_hold();
        test_release_at_long();
        test_lock_held();
        test_reset_mid_repeat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog expired before the sequence completed");
        $fatal(1);
    end

endmodule

// File: doc/button_events.md
Name: button_events

Overview:
- Converts the debounced button level into discrete one-cycle user events: press, release, long-press and auto-repeat.
- Sits directly downstream of the button debouncer and upstream of the VGA controller's mode and pattern select logic.
- The controller consumes pulses only and never inspects the raw level.

Parameters:
CNT_W, 26, width of the hold-time counter
LONG_CYCLES, 25000000, clock cycles a press must be held before long_o fires (0.5 s at 50 MHz); must satisfy 2 <= LONG_CYCLES < 2^CNT_W
REPEAT_CYCLES, 5000000, clock cycles between repeat_o pulses after long press; must satisfy 2 <= REPEAT_CYCLES < 2^CNT_W
REPEAT_EN, 1, 1 = auto-repeat enabled; 0 = no repeat_o pulses ever

Ports:
clock  input  1  single system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
button_i  input  1  debounced button level, 1 = pressed, synchronous to clock
press_o  output  1  one-cycle pulse on press
release_o  output  1  one-cycle pulse on release
long_o  output  1  one-cycle pulse when hold reaches LONG_CYCLES
repeat_o  output  1  one-cycle pulse every REPEAT_CYCLES after long_o
held_o  output  1  level, 1 while a recognised press is in progress

Behaviour:
- All outputs are registered. Reset (reset==0 sampled at an edge) forces state LOCK, counter 0, and all outputs 0. Reset takes priority over everything, including mid-hold.
- States: LOCK, IDLE, PRESS, REPEAT. Counter cnt is CNT_W bits.
- LOCK: button_i==1 stays in LOCK; button_i==0 goes to IDLE. No events are emitted. A button held through reset therefore never produces press_o, and produces no release_o when it is let go.
- IDLE: button_i==1 goes to PRESS with cnt<=0 and press_o<=1.
- PRESS:
  - button_i==0 goes to IDLE with cnt<=0 and release_o<=1.
  - Else if cnt==LONG_CYCLES-1: go to REPEAT with cnt<=0 and long_o<=1.
  - Else cnt<=cnt+1.
- REPEAT:
  - button_i==0 goes to IDLE with cnt<=0 and release_o<=1.
  - Else if REPEAT_EN and cnt==REPEAT_CYCLES-1: cnt<=0 and repeat_o<=1.
  - Else if REPEAT_EN: cnt<=cnt+1.
  - If REPEAT_EN==0, cnt holds at 0.
- Release has priority over a simultaneous long or repeat terminal count. No long_o or repeat_o pulse is emitted in the cycle release is seen.
- Pulse outputs are 1 for exactly one cycle, then 0. At most one of press_o, release_o, long_o and repeat_o is high in any cycle.
- held_o is 1 in every cycle the registered state is PRESS or REPEAT; otherwise 0.
- Latency:
  - press_o is high in the cycle after the edge that first samples button_i==1 in IDLE.
  - long_o is high exactly LONG_CYCLES cycles after press_o.
  - First repeat_o is high REPEAT_CYCLES cycles after long_o, then every REPEAT_CYCLES cycles.
  - release_o is high in the cycle after the edge that first samples button_i==0.
- Minimum press (button_i high for one edge only) gives press_o and release_o in consecutive cycles, with held_o high for one cycle.
- cnt never wraps: it is cleared at each terminal count and can never exceed max(LONG_CYCLES, REPEAT_CYCLES)-1.
- Illegal state encodings recover to LOCK on the next edge.

Test Plan:
- Reset with button_i=0, then press 3 cycles, then release (LONG=8, REPEAT=4) -> press_o 1 cycle, held_o high 3 cycles, release_o 1 cycle, no long_o or repeat_o.
- Hold 20 cycles (LONG=8, REPEAT=4, REPEAT_EN=1) -> press_o at t, long_o at t+8, repeat_o at t+12 and t+16; release_o after the 20th high sample; held_o high t..t+19.
- Same hold with REPEAT_EN=0 -> long_o at t+8 only, no repeat_o, release_o normal.
- Release on the exact edge where cnt==LONG-1 (button high 8 samples, LONG=8) -> release_o pulse, no long_o.
- Button held while reset deasserts, released, pressed again -> no events until the second press, then press_o; no release_o for the first release.
- Assert reset mid-REPEAT -> next cycle all outputs 0 and state LOCK. Button still high gives no events; after release and re-press, the normal press_o sequence resumes.
